// File: rtl/ysyx_22041071_mem_wb_tx.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_mem_wb_tx
//
// Transmit side of the MEM->WB stage interface. It accepts finished MEM-stage
// results, formats load data (byte/half/word extraction with sign or zero
// extension) and buffers them in a 2-entry skid FIFO. A valid/ready handshake
// then presents the results to the WB stage.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous active-low reset (0 = reset asserted)
//   flush        drop every buffered entry; push/pop are ignored that cycle
//   in_valid     MEM result valid
//   in_ready     FIFO can accept a result this cycle
//   in_pc        PC of the instruction
//   in_ins       instruction word
//   in_reg_w_en  instruction writes rd
//   in_rdest     destination register index
//   in_alu_data  non-load result
//   in_is_load   result comes from a memory read
//   in_load_op   load funct3
//   in_rdata     raw 64-bit aligned memory read data
//   in_addr_lo   byte offset of the load address
//   valid6       WB payload valid
//   ready6       WB accepts the payload
//   PC6, Ins5, reg_w_en4, rdest3, WB_data1
//                head entry payload, all zero while the FIFO is empty
// ---------------------------------------------------------------------------
module ysyx_22041071_mem_wb_tx #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INS_W  = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INS_W-1:0]  in_ins,
    input  logic              in_reg_w_en,
    input  logic [4:0]        in_rdest,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic              in_is_load,
    input  logic [2:0]        in_load_op,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [2:0]        in_addr_lo,

    output logic              valid6,
    input  logic              ready6,
    output logic [ADDR_W-1:0] PC6,
    output logic [INS_W-1:0]  Ins5,
    output logic              reg_w_en4,
    output logic [4:0]        rdest3,
    output logic [DATA_W-1:0] WB_data1
);

    // -----------------------------------------------------------------------
    // Load data formatting
    // -----------------------------------------------------------------------
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_word;
    logic [DATA_W-1:0] ld_fmt;
    logic [DATA_W-1:0] wb_data_in;
    logic              reg_w_en_in;

    always_comb begin
        // Offset bits below the access size are ignored by construction.
        ld_byte = in_rdata[{in_addr_lo, 3'b000} +: 8];
        ld_half = in_rdata[{in_addr_lo[2:1], 4'b0000} +: 16];
        ld_word = in_rdata[{in_addr_lo[2], 5'b00000} +: 32];
        ld_fmt  = '0;
        case (in_load_op)
            3'b000:  ld_fmt = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b010:  ld_fmt = {{(DATA_W-32){ld_word[31]}}, ld_word};
            3'b011:  ld_fmt = in_rdata;
            3'b100:  ld_fmt = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b101:  ld_fmt = {{(DATA_W-16){1'b0}}, ld_half};
            3'b110:  ld_fmt = {{(DATA_W-32){1'b0}}, ld_word};
            default: ld_fmt = '0;
        endcase
    end

    assign wb_data_in  = in_is_load ? ld_fmt : in_alu_data;
    // x0 is hard-wired to zero, so never request a write to it.
    assign reg_w_en_in = in_reg_w_en & (in_rdest != 5'd0);

    // -----------------------------------------------------------------------
    // 2-entry FIFO storage and control
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q   [2];
    logic [INS_W-1:0]  ins_q  [2];
    logic              wen_q  [2];
    logic [4:0]        rd_q   [2];
    logic [DATA_W-1:0] data_q [2];

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       push, pop;

    // in_ready looks only at the registered count: no ready6 pass-through.
    assign in_ready = reset & (count_q != 2'd2);
    assign valid6   = (count_q != 2'd0);
    assign push     = in_valid & in_ready;
    assign pop      = valid6 & ready6;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                ins_q[i]  <= '0;
                wen_q[i]  <= 1'b0;
                rd_q[i]   <= 5'd0;
                data_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push && !flush) begin
                pc_q[wr_ptr_q]   <= in_pc;
                ins_q[wr_ptr_q]  <= in_ins;
                wen_q[wr_ptr_q]  <= reg_w_en_in;
                rd_q[wr_ptr_q]   <= in_rdest;
                data_q[wr_ptr_q] <= wb_data_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Head payload, forced to zero while empty
    // -----------------------------------------------------------------------
    always_comb begin
        PC6       = '0;
        Ins5      = '0;
        reg_w_en4 = 1'b0;
        rdest3    = 5'd0;
        WB_data1  = '0;
        if (valid6) begin
            PC6       = pc_q[rd_ptr_q];
            Ins5      = ins_q[rd_ptr_q];
            reg_w_en4 = wen_q[rd_ptr_q];
            rdest3    = rd_q[rd_ptr_q];
            WB_data1  = data_q[rd_ptr_q];
        end
    end

endmodule

// File: doc/ysyx_22041071_mem_wb_tx.md
Name: ysyx_22041071_mem_wb_tx

Overview:
Transmit end of the MEM->WB stage interface. Accepts completed MEM-stage results and formats load data: byte/half/word extraction plus sign or zero extension. Buffers results in a 2-entry skid FIFO and drives the valid/ready handshake and the payload consumed by the WB stage (PC6, Ins5, reg_w_en4, rdest3, WB_data1). Decouples MEM timing from WB back-pressure and supports pipeline flush.

Parameters:
ADDR_W, 64, PC width
INS_W, 32, instruction width
DATA_W, 64, register/data width (fixed 64; load formatting assumes RV64)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset (0 = reset asserted)
flush  in  1  discard all buffered entries this cycle
in_valid  in  1  MEM result valid
in_ready  out  1  FIFO can accept this cycle
in_pc  in  ADDR_W  PC of instruction
in_ins  in  INS_W  instruction word
in_reg_w_en  in  1  instruction writes rd
in_rdest  in  5  destination register index
in_alu_data  in  DATA_W  non-load result
in_is_load  in  1  result comes from memory read
in_load_op  in  3  load funct3
in_rdata  in  DATA_W  raw 64-bit aligned memory read data
in_addr_lo  in  3  byte offset of load address
valid6  out  1  WB payload valid
ready6  in  1  WB accepts payload
PC6  out  ADDR_W  head PC
Ins5  out  INS_W  head instruction
reg_w_en4  out  1  head register write enable
rdest3  out  5  head rd
WB_data1  out  DATA_W  head write-back data

Behaviour:
- Reset (reset==0 at clk edge): count=0, wr/rd pointers=0, both entries cleared. Outputs valid6=0, PC6=0, Ins5=0, reg_w_en4=0, rdest3=0, WB_data1=0. in_ready=0 while reset==0, else per rule below. Reset mid-transfer drops all entries with no partial output.
- Push = in_valid & in_ready. Pop = valid6 & ready6.
- in_ready = reset & (count!=2). Combinational from registered count only; never depends on ready6 (no pass-through at full).
- valid6 = (count!=0). Payload outputs show the head entry. When count==0 all payload outputs are 0.
- Latency: an entry pushed at edge N is visible on valid6/payload after edge N, i.e. 1 cycle. No combinational path from in_* to outputs.
- count update: push&!pop +1; pop&!push -1; push&pop unchanged (legal only at count==1). count never exceeds 2 or underflows.
- Order strictly FIFO; 1-bit wr/rd pointers wrap 1->0.
- flush==1 (and reset==1): count=0, pointers=0 next cycle. Push and pop in the same cycle are ignored; flush has priority. valid6=0 the following cycle.
- Stored reg_w_en = in_reg_w_en & (in_rdest!=0). x0 is never written.
- Stored data = in_is_load ? ld_fmt : in_alu_data.
- ld_fmt by in_load_op (b=in_addr_lo; low bits below access size ignored):
  000 LB: sext(byte[b])
  001 LH: sext(half[b[2:1]])
  010 LW: sext(word[b[2]])
  011 LD: in_rdata
  100 LBU: zext(byte[b])
  101 LHU: zext(half[b[2:1]])
  110 LWU: zext(word[b[2]])
  111 reserved: 0
  byte[k] = in_rdata[8k+7:8k], little-endian.
- Holding: while valid6=1 and ready6=0, payload outputs are stable.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> in_ready=0, valid6=0, all outputs 0. Release -> in_ready=1.
- Single ALU result: push pc=0x80000000, rd=5, alu=0x1234, reg_w_en=1, ready6=1 -> next cycle valid6=1, PC6=0x80000000, rdest3=5, WB_data1=0x1234, reg_w_en4=1. Following cycle valid6=0.
- Load formatting: rdata=0x8877665544332211 -> LB off 7 gives 0xFFFFFFFFFFFFFF88; LBU off 7 gives 0x88; LH off 6 gives 0xFFFFFFFFFFFF8877; LW off 4 gives 0xFFFFFFFF88776655; LWU off 0 gives 0x44332211; op 111 gives 0.
- Back-pressure: ready6=0, push A,B -> in_ready=0 after 2nd push, payload stable at A. Raise ready6 -> A then B delivered in order, in_ready=1 after first pop.
- Steady stream at count==1 with push&pop every cycle -> one result per cycle, count stays 1, no drops or duplicates.
- Flush/x0: with count==2 assert flush together with in_valid -> next cycle valid6=0, count=0, new item dropped. Push reg_w_en=1, rd=0 -> reg_w_en4=0.
